// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: closed-loop speed sequencer.
// Accepts a target speed over valid/ready, compares it against the measured
// speed, and steps the accelerating (af) and braking (bf) force commands at
// a STEP_DIV-cycle tick rate until the speed is within +/-DEADBAND.
// Optional feature macro: SPEED_RAMP_OVERSPEED_EN (sticky overspeed fault).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | disabled or no target yet; af=bf=0
// ACCEL  | speed below deadband; af ramps by ACCEL_STEP per tick
// CRUISE | speed inside deadband; af held, bf=0
// BRAKE  | speed above deadband; bf tracks min(meas-tgt, BRAKE_MAX) per tick
// FAULT  | (optional) overspeed latched; af=0, bf=BRAKE_MAX until enable=0
module speed_ramp_ctrl #(
    parameter int W          = 8,
    parameter int STEP_DIV   = 4,
    parameter int ACCEL_STEP = 10,
    parameter int BRAKE_MAX  = 50,
    parameter int DEADBAND   = 2
`ifdef SPEED_RAMP_OVERSPEED_EN
    ,
    parameter int OVERSPEED_LIM = 240
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_speed,
    input  logic [W-1:0] meas_speed,
    output logic [W-1:0] af,
    output logic [W-1:0] bf,
    output logic [1:0]   state,
    output logic         at_target,
`ifdef SPEED_RAMP_OVERSPEED_EN
    output logic         overspeed,
`endif
    output logic         busy
);

`ifdef SPEED_RAMP_OVERSPEED_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ACCEL = 3'd1, S_CRUISE = 3'd2, S_BRAKE = 3'd3, S_FAULT = 3'd4
    } state_t;
    localparam logic [W-1:0] OVS_LIM = W'(OVERSPEED_LIM);
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0, S_ACCEL = 2'd1, S_CRUISE = 2'd2, S_BRAKE = 2'd3
    } state_t;
`endif

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
    localparam logic [W:0]    MAXV      = {1'b0, {W{1'b1}}};
    localparam logic [W:0]    DB1       = (W+1)'(DEADBAND);
    localparam logic [W:0]    AST1      = (W+1)'(ACCEL_STEP);
    localparam logic [W-1:0]  BMAX      = W'(BRAKE_MAX);

    state_t        st;
    logic [W-1:0]  tgt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          accept;
    logic [W-1:0]  cur_lo, cur_hi, new_lo, new_hi;
    state_t        new_dec, cur_dec;
    logic [W:0]    af_sum;
    logic [W-1:0]  af_next, bf_diff, bf_next;

    // Deadband bounds, saturated at 0 and 2^W-1
    function automatic logic [W-1:0] lo_of(input logic [W-1:0] t);
        logic [W:0] t1;
        t1 = {1'b0, t};
        lo_of = (t1 >= DB1) ? W'(t1 - DB1) : '0;
    endfunction

    function automatic logic [W-1:0] hi_of(input logic [W-1:0] t);
        logic [W:0] s;
        s = {1'b0, t} + DB1;
        hi_of = (s > MAXV) ? MAXV[W-1:0] : s[W-1:0];
    endfunction

    function automatic state_t decide(input logic [W-1:0] m, input logic [W-1:0] lo,
                                      input logic [W-1:0] hi);
        if (m < lo)      decide = S_ACCEL;
        else if (m > hi) decide = S_BRAKE;
        else             decide = S_CRUISE;
    endfunction

    // Handshake, bounds, next-direction decisions and saturated force steps
    always_comb begin
        tgt_ready = rst & enable & ((st == S_IDLE) | (st == S_CRUISE));
        accept    = tgt_valid & tgt_ready;
        tick      = (cnt == TICK_LAST);
        cur_lo    = lo_of(tgt);
        cur_hi    = hi_of(tgt);
        new_lo    = lo_of(tgt_speed);
        new_hi    = hi_of(tgt_speed);
        cur_dec   = decide(meas_speed, cur_lo, cur_hi);
        new_dec   = decide(meas_speed, new_lo, new_hi);
        af_sum    = {1'b0, af} + AST1;
        af_next   = (af_sum > MAXV) ? MAXV[W-1:0] : af_sum[W-1:0];
        bf_diff   = meas_speed - tgt;
        bf_next   = (bf_diff > BMAX) ? BMAX : bf_diff;
    end

    // Sequencer FSM with registered force commands and tick counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= S_IDLE;
            af  <= '0;
            bf  <= '0;
            tgt <= '0;
            cnt <= '0;
`ifdef SPEED_RAMP_OVERSPEED_EN
            overspeed <= 1'b0;
`endif
        end else if (!enable) begin
            st  <= S_IDLE;
            af  <= '0;
            bf  <= '0;
            cnt <= '0;
`ifdef SPEED_RAMP_OVERSPEED_EN
            overspeed <= 1'b0;
        end else if (st != S_IDLE && meas_speed > OVS_LIM) begin
            st        <= S_FAULT;
            af        <= '0;
            bf        <= BMAX;
            cnt       <= '0;
            overspeed <= 1'b1;
`endif
        end else begin
            case (st)
                S_IDLE: begin
                    af  <= '0;
                    bf  <= '0;
                    cnt <= '0;
                    if (accept) begin
                        tgt <= tgt_speed;
                        st  <= new_dec;
                    end
                end
                S_CRUISE: begin
                    bf  <= '0;
                    cnt <= '0;
                    if (accept) begin
                        tgt <= tgt_speed;
                        st  <= new_dec;
                        if (new_dec == S_BRAKE) af <= '0;
                    end else if (cur_dec != S_CRUISE) begin
                        st <= cur_dec;
                        if (cur_dec == S_BRAKE) af <= '0;
                    end
                end
                S_ACCEL: begin
                    bf <= '0;
                    if (meas_speed >= cur_lo) begin
                        st  <= S_CRUISE;
                        cnt <= '0;
                    end else if (tick) begin
                        af  <= af_next;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BRAKE: begin
                    af <= '0;
                    if (meas_speed <= cur_hi) begin
                        st  <= S_CRUISE;
                        bf  <= '0;
                        cnt <= '0;
                    end else if (tick) begin
                        bf  <= bf_next;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    af  <= '0;
                    bf  <= BMAX;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
`ifdef SPEED_RAMP_OVERSPEED_EN
        state = (st == S_FAULT) ? 2'd3 : st[1:0];
        busy  = (st == S_ACCEL) | (st == S_BRAKE) | (st == S_FAULT);
`else
        state = st;
        busy  = (st == S_ACCEL) | (st == S_BRAKE);
`endif
        at_target = (st == S_CRUISE);
    end

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Testbench for speed_ramp_ctrl: table-driven vectors plus hand-written
// corner sequences, checked through an expected-result queue.
module tb_speed_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_speed;
    logic [7:0] meas_speed;
    logic [7:0] af;
    logic [7:0] bf;
    logic [1:0] state;
    logic       at_target;
    logic       busy;
    logic       ovs_dut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    speed_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_speed  (tgt_speed),
        .meas_speed (meas_speed),
        .af         (af),
        .bf         (bf),
        .state      (state),
        .at_target  (at_target),
`ifdef SPEED_RAMP_OVERSPEED_EN
        .overspeed  (ovs_dut),
`endif
        .busy       (busy)
    );

`ifndef SPEED_RAMP_OVERSPEED_EN
    assign ovs_dut = 1'b0;
`endif

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] tgt;
        logic [7:0] meas;
        int         reps;
        logic [1:0] st;
        logic [7:0] af;
        logic [7:0] bf;
        logic       rdy;
        logic       at;
        logic       bsy;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [7:0] af;
        logic [7:0] bf;
        logic       rdy;
        logic       at;
        logic       bsy;
        logic       ovs;
    } exp_t;

    exp_t sb[$];

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(logic en, logic vld, logic [7:0] tgt, logic [7:0] meas, int reps,
                                logic [1:0] st, logic [7:0] a, logic [7:0] b,
                                logic rdy, logic at, logic bsy);
        vec_t v;
        v.en = en; v.vld = vld; v.tgt = tgt; v.meas = meas; v.reps = reps;
        v.st = st; v.af = a; v.bf = b; v.rdy = rdy; v.at = at; v.bsy = bsy;
        return v;
    endfunction

    task automatic check_pop();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: queue empty, nothing expected");
            return;
        end
        e = sb.pop_front();
        if (state !== e.st || af !== e.af || bf !== e.bf || tgt_ready !== e.rdy ||
            at_target !== e.at || busy !== e.bsy || ovs_dut !== e.ovs) begin
            bad++;
            $display("FAIL %s: got st=%0d af=%0d bf=%0d rdy=%b at=%b busy=%b ovs=%b, want st=%0d af=%0d bf=%0d rdy=%b at=%b busy=%b ovs=%b",
                     e.name, state, af, bf, tgt_ready, at_target, busy, ovs_dut,
                     e.st, e.af, e.bf, e.rdy, e.at, e.bsy, e.ovs);
        end
    endtask

    // Drive inputs, queue the expectation, wait reps edges (0 = none), compare.
    task automatic step(input string name, input logic en, input logic vld,
                        input logic [7:0] tgt, input logic [7:0] meas, input int reps,
                        input logic [1:0] st, input logic [7:0] a, input logic [7:0] b,
                        input logic rdy, input logic at, input logic bsy, input logic ovs);
        exp_t e;
        enable = en; tgt_valid = vld; tgt_speed = tgt; meas_speed = meas;
        e.name = name; e.st = st; e.af = a; e.bf = b;
        e.rdy = rdy; e.at = at; e.bsy = bsy; e.ovs = ovs;
        sb.push_back(e);
        if (reps > 0) begin
            repeat (reps) @(posedge clk);
        end
        #1;
        check_pop();
    endtask

    initial begin
        //           en vld tgt  meas reps  st af   bf  rdy at bsy
        vecs[0]  = mk(1, 1, 100,   0,  1,  1,  0,   0, 0, 0, 1); // accept -> ACCEL
        vecs[1]  = mk(1, 0, 100,   0,  3,  1,  0,   0, 0, 0, 1);
        vecs[2]  = mk(1, 0, 100,   0,  1,  1, 10,   0, 0, 0, 1); // 4th cycle
        vecs[3]  = mk(1, 0, 100,   0,  4,  1, 20,   0, 0, 0, 1);
        vecs[4]  = mk(1, 0, 100,   0,  4,  1, 30,   0, 0, 0, 1);
        vecs[5]  = mk(1, 0, 100,  98,  1,  2, 30,   0, 1, 1, 0); // meas==lo -> CRUISE
        vecs[6]  = mk(1, 0, 100, 160,  1,  3,  0,   0, 0, 0, 1); // -> BRAKE
        vecs[7]  = mk(1, 0, 100, 160,  3,  3,  0,   0, 0, 0, 1);
        vecs[8]  = mk(1, 0, 100, 160,  1,  3,  0,  50, 0, 0, 1); // clamp
        vecs[9]  = mk(1, 0, 100, 120,  4,  3,  0,  20, 0, 0, 1);
        vecs[10] = mk(1, 0, 100, 102,  1,  2,  0,   0, 1, 1, 0); // meas==hi -> CRUISE
        vecs[11] = mk(0, 0, 100,   0,  1,  0,  0,   0, 0, 0, 0);
        vecs[12] = mk(1, 1,   1,   0,  1,  2,  0,   0, 1, 1, 0); // lo saturates at 0
        vecs[13] = mk(1, 1,  50,  48,  1,  2,  0,   0, 1, 1, 0); // re-target in CRUISE
        vecs[14] = mk(1, 0,  50,  47,  1,  1,  0,   0, 0, 0, 1);
        vecs[15] = mk(1, 0,  50,  52,  1,  2,  0,   0, 1, 1, 0);
        vecs[16] = mk(1, 0,  50,  53,  1,  3,  0,   0, 0, 0, 1);
        vecs[17] = mk(1, 0,  50,  52,  1,  2,  0,   0, 1, 1, 0);
        vecs[18] = mk(0, 1, 200,  52,  1,  0,  0,   0, 0, 0, 0); // enable beats valid
        vecs[19] = mk(1, 0, 200,   0,  1,  0,  0,   0, 1, 0, 0);
        vecs[20] = mk(1, 1, 255,   0,  1,  1,  0,   0, 0, 0, 1);
        vecs[21] = mk(1, 1,   0,   0, 99,  1, 240,  0, 0, 0, 1); // valid ignored while busy
        vecs[22] = mk(1, 0,   0,   0,  1,  1, 250,  0, 0, 0, 1);
        vecs[23] = mk(1, 0,   0,   0,  4,  1, 255,  0, 0, 0, 1); // saturate
        vecs[24] = mk(1, 0,   0,   0,  4,  1, 255,  0, 0, 0, 1); // no wrap

        rst = 1'b0; enable = 1'b1; tgt_valid = 1'b0; tgt_speed = 8'd0; meas_speed = 8'd0;
        step("reset_state", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].vld, vecs[i].tgt, vecs[i].meas,
                 vecs[i].reps, vecs[i].st, vecs[i].af, vecs[i].bf,
                 vecs[i].rdy, vecs[i].at, vecs[i].bsy, 1'b0);
        end

        // Asynchronous reset while ramping at af=30
        step("disable", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("re_accept", 1, 1, 100, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step("ramp_to_30", 1, 0, 100, 0, 12, 1, 30, 0, 0, 0, 1, 0);
        #3;
        rst = 1'b0;
        step("async_reset", 1, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("after_reset", 1, 0, 100, 0, 1, 0, 0, 0, 1, 0, 0, 0);

`ifdef SPEED_RAMP_OVERSPEED_EN
        step("ovs_accept", 1, 1, 100, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step("ovs_trip", 1, 0, 100, 241, 1, 3, 0, 50, 0, 0, 1, 1);
        step("ovs_sticky", 1, 0, 100, 0, 3, 3, 0, 50, 0, 0, 1, 1);
        step("ovs_clear", 0, 0, 100, 0, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speed_ramp_ctrl.md
Name: speed_ramp_ctrl

Overview:
Closed-loop sequencer for the motor speed datapath. Accepts a target speed over a valid/ready handshake, compares it against the measured speed, and issues stepped accelerating-force (af) and braking-force (bf) commands. The commands are issued at a programmable update rate until the measured speed settles inside a deadband around the target. Sits between the host/command logic and the speed integrator; af/bf drive the integrator's force inputs.

Parameters:
W, 8, width of speed/force values
STEP_DIV, 4, clk cycles per force update tick (>=1)
ACCEL_STEP, 10, af increment per tick in ACCEL
BRAKE_MAX, 50, maximum bf magnitude
DEADBAND, 2, +/- tolerance around target treated as "at target"
OVERSPEED_LIM, 240, fault threshold (only used with optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  run enable; low forces IDLE
tgt_valid  in  1  new target offered
tgt_ready  out  1  target can be accepted this cycle
tgt_speed  in  W  target speed, sampled on tgt_valid&tgt_ready
meas_speed  in  W  measured speed from datapath
af  out  W  accelerating force command (registered)
bf  out  W  braking force command (registered)
state  out  2  0=IDLE 1=ACCEL 2=CRUISE 3=BRAKE
at_target  out  1  state==CRUISE
busy  out  1  state is ACCEL or BRAKE

Behaviour:
- Reset (rst=0, async): state=IDLE, af=0, bf=0, latched target=0, tick counter=0; tgt_ready=0, at_target=0, busy=0 while in reset.
- lo = max(tgt-DEADBAND, 0); hi = min(tgt+DEADBAND, 2^W-1); computed in W+1 bits, saturated.
- tgt_ready = enable & (state==IDLE | state==CRUISE). Accept = tgt_valid & tgt_ready; target latched at that edge.
- Tick counter: cleared on every state entry; counts 0..STEP_DIV-1 in ACCEL/BRAKE; tick = (count==STEP_DIV-1), then wraps to 0. Held at 0 in IDLE/CRUISE.
- Transitions are evaluated every cycle against the current latched target. af/bf are updated only on tick, except where noted.
- IDLE: af=bf=0. On accept, the next state is decided from the new target: meas<lo -> ACCEL; meas>hi -> BRAKE; else CRUISE.
- ACCEL: bf=0. On tick, af=min(af+ACCEL_STEP, 2^W-1), saturating with no wrap. If meas>=lo -> CRUISE; af is held at its current value.
- BRAKE: af=0 on entry. On tick, bf=min(meas-tgt, BRAKE_MAX). If meas<=hi -> CRUISE; bf=0 at the transition edge.
- CRUISE: af held, bf=0.
  - Accept with a new target: re-evaluate as in IDLE.
  - Otherwise meas<lo -> ACCEL; meas>hi -> BRAKE.
- ACCEL<->BRAKE are never direct; the path always goes through CRUISE.
- enable=0 in any state: next edge state=IDLE, af=bf=0, counter=0. Enable takes priority over a simultaneous tgt_valid, since tgt_ready=0.
- tgt_valid while busy: not accepted. The requester holds tgt_valid until ready.
- meas==lo or meas==hi counts as inside the deadband.

Optional Feature:
SPEED_RAMP_OVERSPEED_EN
- Defined:
  - Adds output `overspeed` (1 bit, sticky).
  - Reuses encoding 3 as BRAKE and adds internal FAULT state, reported as state=3 with overspeed=1.
  - meas_speed>OVERSPEED_LIM in any non-IDLE state -> FAULT next edge: af=0, bf=BRAKE_MAX, tgt_ready=0, busy=1.
  - FAULT exits only via enable=0 (-> IDLE, overspeed cleared) or reset.
- Undefined: no port, no FAULT state, OVERSPEED_LIM ignored.

Test Plan:
1. Reset mid-ACCEL (af=30) with rst=0 -> af=0, bf=0, state=IDLE immediately, without waiting for a clock edge.
2. Defaults, enable=1, meas=0, offer tgt=100 -> accepted in 1 cycle; state=ACCEL; af=10,20,30 on the 4th, 8th and 12th ACCEL cycles; set meas=98 -> CRUISE next edge, af held, at_target=1.
3. In CRUISE tgt=100, meas=160 -> BRAKE; first tick bf=50 (clamped); meas=120 -> next tick bf=20; meas=102 -> CRUISE, bf=0.
4. tgt=1, meas=0 (lo saturates to 0) -> CRUISE directly. tgt=255 with af at 250 in ACCEL -> af saturates at 255, never wraps.
5. tgt_valid held during ACCEL -> tgt_ready=0, no latch. Deassert enable in the same cycle as tgt_valid in CRUISE -> IDLE, target unchanged.
6. With SPEED_RAMP_OVERSPEED_EN: meas=241 in ACCEL -> overspeed=1, bf=50, af=0. meas drops to 0 -> stays in FAULT. enable=0 -> IDLE, overspeed=0.
